// File: rtl/finish_gen_pkg.sv
// Shared types and default sizing for the multi-channel finish generator.
// The optional idle watchdog is enabled by defining FINISH_GEN_TIMEOUT_EN.
package finish_gen_pkg;

    typedef enum logic [1:0] {
        FG_IDLE  = 2'd0,
        FG_COUNT = 2'd1,
        FG_DONE  = 2'd2
    } fg_state_e;

    localparam int FG_NUM_CH_DEF = 4;
    localparam int FG_CNT_W_DEF  = 32;
    localparam int FG_TO_CYC_DEF = 1024;

endpackage

// File: rtl/finish_gen_ch.sv
// One finish-generator channel: target latch, strobe counter, sticky finish and pulse.
// With FINISH_GEN_TIMEOUT_EN defined, an idle watchdog can force completion and flag timeout.
module finish_gen_ch
    import finish_gen_pkg::*;
#(
    parameter int CNT_W  = FG_CNT_W_DEF,
    parameter int TO_CYC = FG_TO_CYC_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             clear,
    input  logic             cnt_enable,
    input  logic [CNT_W-1:0] total_num,
    output logic             finish,
    output logic             finish_pulse,
    output logic [CNT_W-1:0] cnt_val
`ifdef FINISH_GEN_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    fg_state_e        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] target_reg;
    logic             finish_reg;
    logic             pulse_reg;
    logic [CNT_W-1:0] cnt_next;

    // cnt_reg is always below target_reg while counting, so this never wraps.
    assign cnt_next = cnt_reg + CNT_W'(1);

`ifdef FINISH_GEN_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYC + 1);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TO_CYC);

    logic [TO_W-1:0] idle_reg;
    logic [TO_W-1:0] idle_next;
    logic            timeout_reg;

    assign idle_next = idle_reg + TO_W'(1);
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg   <= FG_IDLE;
            cnt_reg     <= '0;
            target_reg  <= '0;
            finish_reg  <= 1'b0;
            pulse_reg   <= 1'b0;
`ifdef FINISH_GEN_TIMEOUT_EN
            idle_reg    <= '0;
            timeout_reg <= 1'b0;
`endif
        end else if (clear) begin
            // Target is kept; it is re-latched on the next start anyway.
            state_reg   <= FG_IDLE;
            cnt_reg     <= '0;
            finish_reg  <= 1'b0;
            pulse_reg   <= 1'b0;
`ifdef FINISH_GEN_TIMEOUT_EN
            idle_reg    <= '0;
            timeout_reg <= 1'b0;
`endif
        end else begin
            pulse_reg <= 1'b0;
            case (state_reg)
                FG_IDLE: begin
                    if (enable) begin
                        target_reg <= total_num;
                        cnt_reg    <= '0;
`ifdef FINISH_GEN_TIMEOUT_EN
                        idle_reg   <= '0;
`endif
                        if (total_num == '0) begin
                            state_reg  <= FG_DONE;
                            finish_reg <= 1'b1;
                            pulse_reg  <= 1'b1;
                        end else begin
                            state_reg <= FG_COUNT;
                        end
                    end
                end
                FG_COUNT: begin
                    if (enable) begin
                        if (cnt_enable) begin
                            cnt_reg  <= cnt_next;
`ifdef FINISH_GEN_TIMEOUT_EN
                            idle_reg <= '0;
`endif
                            if (cnt_next == target_reg) begin
                                state_reg  <= FG_DONE;
                                finish_reg <= 1'b1;
                                pulse_reg  <= 1'b1;
                            end
                        end
`ifdef FINISH_GEN_TIMEOUT_EN
                        else begin
                            idle_reg <= idle_next;
                            if (idle_next == TO_LIM) begin
                                state_reg   <= FG_DONE;
                                finish_reg  <= 1'b1;
                                pulse_reg   <= 1'b1;
                                timeout_reg <= 1'b1;
                            end
                        end
`endif
                    end
                end
                FG_DONE: begin
                    state_reg <= FG_DONE;
                end
                default: begin
                    state_reg <= FG_IDLE;
                end
            endcase
        end
    end

    assign finish       = finish_reg;
    assign finish_pulse = pulse_reg;
    assign cnt_val      = cnt_reg;
`ifdef FINISH_GEN_TIMEOUT_EN
    assign timeout      = timeout_reg;
`endif

endmodule

// File: rtl/finish_gen_multi.sv
// NUM_CH independent finish-generator channels with a combined all_finish flag.
// Defining FINISH_GEN_TIMEOUT_EN adds the per-channel idle watchdog and timeout output.
module finish_gen_multi
    import finish_gen_pkg::*;
#(
    parameter int NUM_CH = FG_NUM_CH_DEF,
    parameter int CNT_W  = FG_CNT_W_DEF,
    parameter int TO_CYC = FG_TO_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [NUM_CH-1:0]       ch_clear,
    input  logic [NUM_CH-1:0]       cnt_enable,
    input  logic [NUM_CH*CNT_W-1:0] total_num,
    output logic [NUM_CH-1:0]       finish,
    output logic [NUM_CH-1:0]       finish_pulse,
    output logic                    all_finish,
    output logic [NUM_CH*CNT_W-1:0] cnt_val
`ifdef FINISH_GEN_TIMEOUT_EN
    ,
    output logic [NUM_CH-1:0]       timeout
`endif
);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            finish_gen_ch #(
                .CNT_W  (CNT_W),
                .TO_CYC (TO_CYC)
            ) u_ch (
                .clk          (clk),
                .rstn         (rstn),
                .enable       (enable),
                .clear        (clear | ch_clear[gi]),
                .cnt_enable   (cnt_enable[gi]),
                .total_num    (total_num[gi*CNT_W +: CNT_W]),
                .finish       (finish[gi]),
                .finish_pulse (finish_pulse[gi]),
                .cnt_val      (cnt_val[gi*CNT_W +: CNT_W])
`ifdef FINISH_GEN_TIMEOUT_EN
                ,
                .timeout      (timeout[gi])
`endif
            );
        end
    endgenerate

    // Straight AND of registered levels: rises in the same cycle as the last finish.
    assign all_finish = &finish;

endmodule

// File: tb/tb_finish_gen_multi.sv
// Directed self-checking bench for finish_gen_multi: a 4x32 instance and a 1x4 instance.
// Watchdog checks run only when FINISH_GEN_TIMEOUT_EN is defined.
module tb_finish_gen_multi;

    logic         clk;
    logic         rstn;
    logic         enable;
    logic         clear;
    logic [3:0]   ch_clear;
    logic [3:0]   cnt_enable;
    logic [127:0] total_num;
    logic [3:0]   finish;
    logic [3:0]   finish_pulse;
    logic         all_finish;
    logic [127:0] cnt_val;
    logic [3:0]   timeout;

    logic         w_enable;
    logic         w_clear;
    logic [0:0]   w_ch_clear;
    logic [0:0]   w_cnt_enable;
    logic [3:0]   w_total_num;
    logic [0:0]   w_finish;
    logic [0:0]   w_finish_pulse;
    logic         w_all_finish;
    logic [3:0]   w_cnt_val;
    logic [0:0]   w_timeout;

    int n_cmp = 0;
    int n_mis = 0;

    finish_gen_multi #(.NUM_CH(4), .CNT_W(32), .TO_CYC(8)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .clear        (clear),
        .ch_clear     (ch_clear),
        .cnt_enable   (cnt_enable),
        .total_num    (total_num),
        .finish       (finish),
        .finish_pulse (finish_pulse),
        .all_finish   (all_finish),
        .cnt_val      (cnt_val)
`ifdef FINISH_GEN_TIMEOUT_EN
        ,
        .timeout      (timeout)
`endif
    );

    finish_gen_multi #(.NUM_CH(1), .CNT_W(4), .TO_CYC(8)) dut_w (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (w_enable),
        .clear        (w_clear),
        .ch_clear     (w_ch_clear),
        .cnt_enable   (w_cnt_enable),
        .total_num    (w_total_num),
        .finish       (w_finish),
        .finish_pulse (w_finish_pulse),
        .all_finish   (w_all_finish),
        .cnt_val      (w_cnt_val)
`ifdef FINISH_GEN_TIMEOUT_EN
        ,
        .timeout      (w_timeout)
`endif
    );

`ifndef FINISH_GEN_TIMEOUT_EN
    assign timeout   = '0;
    assign w_timeout = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt_of(input int ch);
        return cnt_val[ch*32 +: 32];
    endfunction

    logic [3:0] exp_fin [0:8];
    int         pulse_cnt [4];

    initial begin
        rstn       = 1'b0;
        enable     = 1'b0;
        clear      = 1'b0;
        ch_clear   = '0;
        cnt_enable = '0;
        total_num  = '0;
        w_enable     = 1'b0;
        w_clear      = 1'b0;
        w_ch_clear   = '0;
        w_cnt_enable = '0;
        w_total_num  = '0;
        exp_fin = '{4'h0, 4'h4, 4'h6, 4'h6, 4'h7, 4'h7, 4'hF, 4'hF, 4'hF};
        for (int c = 0; c < 4; c++) pulse_cnt[c] = 0;

        // Reset state
        tick();
        tick();
        check_val("rst_finish", 64'(finish), 64'h0);
        check_val("rst_pulse", 64'(finish_pulse), 64'h0);
        check_val("rst_all", 64'(all_finish), 64'h0);
        check_val("rst_cnt_lo", cnt_val[63:0], 64'h0);
        check_val("rst_cnt_hi", cnt_val[127:64], 64'h0);
        check_val("rst_w_cnt", 64'(w_cnt_val), 64'h0);
        rstn = 1'b1;
        tick();

        // Targets {ch0=3, ch1=1, ch2=0, ch3=5}, strobes every cycle
        total_num  = {32'd5, 32'd0, 32'd1, 32'd3};
        enable     = 1'b1;
        cnt_enable = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_val($sformatf("t1_finish_c%0d", k), 64'(finish), 64'(exp_fin[k]));
            check_val($sformatf("t1_pulse_c%0d", k), 64'(finish_pulse), 64'(exp_fin[k] & ~exp_fin[k-1]));
            check_val($sformatf("t1_all_c%0d", k), 64'(all_finish), 64'(exp_fin[k] == 4'hF));
            for (int c = 0; c < 4; c++) if (finish_pulse[c]) pulse_cnt[c]++;
        end
        for (int c = 0; c < 4; c++) check_val($sformatf("t1_npulse_ch%0d", c), 64'(pulse_cnt[c]), 64'd1);
        check_val("t1_cnt0", 64'(cnt_of(0)), 64'd3);
        check_val("t1_cnt1", 64'(cnt_of(1)), 64'd1);
        check_val("t1_cnt2", 64'(cnt_of(2)), 64'd0);
        check_val("t1_cnt3", 64'(cnt_of(3)), 64'd5);

        // Pause: ch0 target 4, 2 strobes, 10 paused cycles, 2 more strobes
        clear      = 1'b1;
        enable     = 1'b0;
        total_num  = {32'd100, 32'd100, 32'd100, 32'd4};
        tick();
        check_val("t2_clear_finish", 64'(finish), 64'h0);
        clear  = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        tick();
        check_val("t2_cnt_pre", 64'(cnt_of(0)), 64'd2);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_val($sformatf("t2_pause_cnt%0d", k), 64'(cnt_of(0)), 64'd2);
        end
        enable = 1'b1;
        tick();
        check_val("t2_cnt3", 64'(cnt_of(0)), 64'd3);
        check_val("t2_fin3", 64'(finish[0]), 64'd0);
        tick();
        check_val("t2_cnt4", 64'(cnt_of(0)), 64'd4);
        check_val("t2_fin4", 64'(finish[0]), 64'd1);
        check_val("t2_pulse4", 64'(finish_pulse[0]), 64'd1);

        // ch_clear on ch1 together with its strobe
        clear     = 1'b1;
        total_num = {32'd100, 32'd100, 32'd5, 32'd100};
        tick();
        clear = 1'b0;
        tick();
        tick();
        tick();
        check_val("t3_cnt1_pre", 64'(cnt_of(1)), 64'd2);
        ch_clear = 4'b0010;
        tick();
        check_val("t3_cnt1_clr", 64'(cnt_of(1)), 64'd0);
        check_val("t3_cnt0_clr", 64'(cnt_of(0)), 64'd3);
        check_val("t3_cnt2_clr", 64'(cnt_of(2)), 64'd3);
        check_val("t3_cnt3_clr", 64'(cnt_of(3)), 64'd3);
        ch_clear = 4'b0000;
        tick();
        check_val("t3_cnt1_start", 64'(cnt_of(1)), 64'd0);
        tick();
        check_val("t3_cnt1_run", 64'(cnt_of(1)), 64'd1);
        check_val("t3_cnt0_run", 64'(cnt_of(0)), 64'd5);

        // Reset mid-count, then restart with new targets
        rstn = 1'b0;
        tick();
        check_val("t4_rst_finish", 64'(finish), 64'h0);
        check_val("t4_rst_pulse", 64'(finish_pulse), 64'h0);
        check_val("t4_rst_all", 64'(all_finish), 64'h0);
        check_val("t4_rst_cnt_lo", cnt_val[63:0], 64'h0);
        check_val("t4_rst_cnt_hi", cnt_val[127:64], 64'h0);
        rstn      = 1'b1;
        total_num = {32'd2, 32'd2, 32'd2, 32'd2};
        tick();
        tick();
        check_val("t4_fin_mid", 64'(finish), 64'h0);
        tick();
        check_val("t4_fin_done", 64'(finish), 64'hF);
        check_val("t4_all_done", 64'(all_finish), 64'h1);

        // 4-bit counter to its maximum target
        w_total_num  = 4'd15;
        w_enable     = 1'b1;
        w_cnt_enable = 1'b1;
        tick();
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 14) begin
                check_val("t5_cnt14", 64'(w_cnt_val), 64'd14);
                check_val("t5_fin14", 64'(w_finish), 64'd0);
            end
        end
        check_val("t5_cnt15", 64'(w_cnt_val), 64'd15);
        check_val("t5_fin15", 64'(w_finish), 64'd1);
        check_val("t5_pulse15", 64'(w_finish_pulse), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val($sformatf("t5_hold_cnt%0d", k), 64'(w_cnt_val), 64'd15);
            check_val($sformatf("t5_hold_pulse%0d", k), 64'(w_finish_pulse), 64'd0);
        end
        check_val("t5_timeout_off", 64'(w_timeout), 64'd0);

`ifdef FINISH_GEN_TIMEOUT_EN
        // Watchdog: ch0 target 5, 2 strobes, then idle for TO_CYC=8 cycles
        clear      = 1'b1;
        total_num  = {32'd5, 32'd5, 32'd5, 32'd5};
        cnt_enable = 4'b0000;
        tick();
        clear = 1'b0;
        tick();
        cnt_enable = 4'b0001;
        tick();
        tick();
        check_val("t6_cnt2", 64'(cnt_of(0)), 64'd2);
        cnt_enable = 4'b0000;
        for (int k = 1; k <= 7; k++) tick();
        check_val("t6_to_7", 64'(timeout[0]), 64'd0);
        check_val("t6_fin_7", 64'(finish[0]), 64'd0);
        tick();
        check_val("t6_to_8", 64'(timeout[0]), 64'd1);
        check_val("t6_fin_8", 64'(finish[0]), 64'd1);
        check_val("t6_pulse_8", 64'(finish_pulse[0]), 64'd1);
        tick();
        check_val("t6_pulse_9", 64'(finish_pulse[0]), 64'd0);
        clear = 1'b1;
        tick();
        check_val("t6_clr_to", 64'(timeout), 64'h0);
        check_val("t6_clr_fin", 64'(finish), 64'h0);
        clear = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
